reg_bank_p: RTL
===============

REG_BANK_P -- requirements
Module: reg_bank_p

Interface
REQ-001 SHALL have parameter DW, default 16, data width of every register and data port.
REQ-002 SHALL have parameter NREG, default 36, number of registers; AW = clog2(NREG), default 6.
REQ-003 SHALL have parameters WR_IDX=34, AUX_IDX=35, PO0_IDX=30, PO1_IDX=31, PI0_IDX=32, PI1_IDX=33, special register indices.
REQ-004 SHALL have parameter TIMEOUT, default 15, maximum cycles waiting for mem_ack.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 c_addr  in  AW  write (bus C) register index; c_data  in  DW  write data.
REQ-008 wr_en  in  1  general register write; wr_wr_en  in  1  working-register write; aux_en  in  1  AUX register write.
REQ-009 a_addr  in  AW, b_addr  in  AW  read indices; rd_en  in  1  read strobe.
REQ-010 a_data  out  DW, b_data  out  DW  registered operands.
REQ-011 mem_rd  in  1, mem_wr  in  1  memory transfer requests for working register.
REQ-012 mem_req  out  1, mem_we  out  1, mem_wdata  out  DW, mem_rdata  in  DW, mem_ack  in  1  memory handshake.
REQ-013 busy  out  1  transfer in progress; mem_err  out  1  sticky timeout flag.
REQ-014 pi0, pi1  in  DW  input ports; po0, po1, wr_q, aux_q  out  DW  register views.

Function
REQ-015 C write with wr_en=1 SHALL update Register[c_addr] at edge only if c_addr < NREG and c_addr not in {WR_IDX, AUX_IDX, PI0_IDX, PI1_IDX}; otherwise dropped.
REQ-016 wr_wr_en=1 with c_addr==WR_IDX SHALL update Register[WR_IDX]; wr_wr_en with any other c_addr is dropped.
REQ-017 aux_en=1 SHALL update Register[AUX_IDX] from c_data regardless of c_addr.
REQ-018 Register[PI0_IDX], Register[PI1_IDX] SHALL sample pi0, pi1 every edge (read-only, one-cycle latency).
REQ-019 rd_en=1 SHALL load a_data/b_data with Register[a_addr]/Register[b_addr] at edge; rd_en=0 holds them.
REQ-020 Read of an index with a write committing the same edge SHALL return the new data (write-through bypass); out-of-range index returns 0.
REQ-021 po0, po1, wr_q, aux_q SHALL equal current register contents (new value visible the cycle after a write edge).
REQ-022 Memory FSM states IDLE, RD_WAIT, WR_WAIT; busy=1 exactly when not IDLE.
REQ-023 IDLE: mem_rd=1 -> RD_WAIT, mem_req=1, mem_we=0; else mem_wr=1 -> WR_WAIT, mem_req=1, mem_we=1, mem_wdata latched from Register[WR_IDX] (bypassed if written same edge); mem_rd wins if both; new request clears mem_err.
REQ-024 RD_WAIT + mem_ack SHALL write mem_rdata to Register[WR_IDX], drop mem_req, return to IDLE next edge.
REQ-025 WR_WAIT + mem_ack SHALL drop mem_req and return to IDLE; mem_wdata held constant throughout WR_WAIT.
REQ-026 mem_rd/mem_wr while busy SHALL be ignored; mem_ack in IDLE ignored.
REQ-027 C-port writes to WR_IDX during RD_WAIT SHALL be dropped; during WR_WAIT they are accepted without altering mem_wdata.
REQ-028 Wait counter SHALL count cycles in RD_WAIT/WR_WAIT; reaching TIMEOUT without ack -> IDLE, mem_req=0, mem_err=1, Register[WR_IDX] unchanged.
REQ-029 mem_ack on the same cycle the counter reaches TIMEOUT SHALL be treated as success.

Reset
REQ-030 rst_n=0 SHALL immediately clear all registers, a_data, b_data, mem_wdata, wait counter to 0, FSM to IDLE, mem_req, mem_we, busy, mem_err to 0.
REQ-031 Reset mid-transfer SHALL abort it; a late mem_ack after reset release is ignored.

Verification
REQ-032 Write c_addr=5, c_data=0x1234, wr_en=1, same edge rd_en=1, a_addr=5 -> a_data=0x1234 after that edge.
REQ-033 wr_en=1, c_addr=34, c_data=0xFFFF -> wr_q unchanged; repeat with wr_wr_en=1 -> wr_q=0xFFFF; c_addr=32 write -> register still tracks pi0.
REQ-034 mem_rd=1, mem_ack after 3 cycles with mem_rdata=0xBEEF -> busy high 3 cycles, wr_q=0xBEEF, FSM IDLE.
REQ-035 mem_rd and mem_wr both 1 -> mem_we=0; never ack -> mem_err=1 and mem_req=0 after 15 wait cycles, wr_q unchanged.
REQ-036 wr_q=0x00A5, mem_wr=1, then wr_wr_en write 0x5A5A during WR_WAIT -> mem_wdata stays 0x00A5; rst_n low mid-wait -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/reg_bank_p_if.sv
// Memory handshake used by reg_bank_p to move its working register to and from memory.
// The bank is the master: it raises requests, memory answers with ack and read data.
interface reg_bank_p_if #(
    parameter int unsigned DW = 16
);
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/reg_bank_p.sv
// Register bank with write bus C, two registered read ports, I/O port registers and a
// working register that can be transferred to/from memory under a timeout-guarded FSM.
module reg_bank_p #(
    parameter int unsigned DW      = 16,
    parameter int unsigned NREG    = 36,
    parameter int unsigned AW      = $clog2(NREG),
    parameter int unsigned WR_IDX  = 34,
    parameter int unsigned AUX_IDX = 35,
    parameter int unsigned PO0_IDX = 30,
    parameter int unsigned PO1_IDX = 31,
    parameter int unsigned PI0_IDX = 32,
    parameter int unsigned PI1_IDX = 33,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_data,
    input  logic          wr_en,
    input  logic          wr_wr_en,
    input  logic          aux_en,
    input  logic [AW-1:0] a_addr,
    input  logic [AW-1:0] b_addr,
    input  logic          rd_en,
    output logic [DW-1:0] a_data,
    output logic [DW-1:0] b_data,
    input  logic          mem_rd,
    input  logic          mem_wr,
    output logic          busy,
    output logic          mem_err,
    input  logic [DW-1:0] pi0,
    input  logic [DW-1:0] pi1,
    output logic [DW-1:0] po0,
    output logic [DW-1:0] po1,
    output logic [DW-1:0] wr_q,
    output logic [DW-1:0] aux_q,
    reg_bank_p_if.master  mem
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [AW-1:0] WrA  = AW'(WR_IDX);
    localparam logic [AW-1:0] AuxA = AW'(AUX_IDX);
    localparam logic [AW-1:0] Pi0A = AW'(PI0_IDX);
    localparam logic [AW-1:0] Pi1A = AW'(PI1_IDX);

    typedef enum logic [1:0] {StIdle, StRdWait, StWrWait} state_e;

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic [DW-1:0] a_data_q, b_data_q, a_data_d, b_data_d;
    logic [DW-1:0] mem_wdata_q;
    logic [CW-1:0] cnt_q;
    state_e        state_q;
    logic          mem_req_q, mem_we_q, busy_q, mem_err_q;

    logic gen_wr_ok, wr_wr_ok, rd_done;

    assign gen_wr_ok = wr_en && (32'(c_addr) < NREG) && (c_addr != WrA) && (c_addr != AuxA)
                       && (c_addr != Pi0A) && (c_addr != Pi1A);
    // Working register is owned by the memory read while one is outstanding.
    assign wr_wr_ok  = wr_wr_en && (c_addr == WrA) && (state_q != StRdWait);
    assign rd_done   = (state_q == StRdWait) && mem.mem_ack;

    // Next-state register image; reads and mem_wdata latch from it to get write-through.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (gen_wr_ok && (c_addr == AW'(i))) begin
                regs_d[i] = c_data;
            end
        end
        regs_d[PI0_IDX] = pi0;
        regs_d[PI1_IDX] = pi1;
        if (aux_en) begin
            regs_d[AUX_IDX] = c_data;
        end
        if (rd_done) begin
            regs_d[WR_IDX] = mem.mem_rdata;
        end else if (wr_wr_ok) begin
            regs_d[WR_IDX] = c_data;
        end
    end

    always_comb begin
        a_data_d = '0;
        b_data_d = '0;
        for (int i = 0; i < NREG; i++) begin
            if (a_addr == AW'(i)) begin
                a_data_d = regs_d[i];
            end
            if (b_addr == AW'(i)) begin
                b_data_d = regs_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            a_data_q <= '0;
            b_data_q <= '0;
        end else begin
            regs_q <= regs_d;
            if (rd_en) begin
                a_data_q <= a_data_d;
                b_data_q <= b_data_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            mem_err_q   <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mem_rd) begin
                        state_q   <= StRdWait;
                        cnt_q     <= CW'(1);
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                        busy_q    <= 1'b1;
                        mem_err_q <= 1'b0;
                    end else if (mem_wr) begin
                        state_q     <= StWrWait;
                        cnt_q       <= CW'(1);
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        mem_err_q   <= 1'b0;
                        mem_wdata_q <= regs_d[WR_IDX];
                    end
                end
                StRdWait, StWrWait: begin
                    // cnt_q is the number of the current wait cycle; ack on the last one wins.
                    if (mem.mem_ack) begin
                        state_q   <= StIdle;
                        cnt_q     <= '0;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        state_q   <= StIdle;
                        cnt_q     <= '0;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        mem_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    cnt_q     <= '0;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign a_data        = a_data_q;
    assign b_data        = b_data_q;
    assign busy          = busy_q;
    assign mem_err       = mem_err_q;
    assign po0           = regs_q[PO0_IDX];
    assign po1           = regs_q[PO1_IDX];
    assign wr_q          = regs_q[WR_IDX];
    assign aux_q         = regs_q[AUX_IDX];
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule
